// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding memory port.
// Define ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that completes a stalled access with err.
module mem_port_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            core_clk_i,
    input  logic            core_reset_i,
    input  logic            r0_req_i,
    input  logic            r0_we_i,
    input  logic [XLEN-1:0] r0_addr_i,
    input  logic [XLEN-1:0] r0_wdata_i,
    output logic            r0_ack_o,
    output logic [XLEN-1:0] r0_rdata_o,
    output logic            r0_err_o,
    input  logic            r1_req_i,
    input  logic            r1_we_i,
    input  logic [XLEN-1:0] r1_addr_i,
    input  logic [XLEN-1:0] r1_wdata_i,
    output logic            r1_ack_o,
    output logic [XLEN-1:0] r1_rdata_o,
    output logic            r1_err_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_write_data_o,
    output logic            mem_read_en_o,
    output logic            mem_write_en_o,
    input  logic [XLEN-1:0] mem_read_data_i,
    input  logic            mem_done_i,
    output logic            busy_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]      state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            resp;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (r0_req_i || r1_req_i) begin
                    // On a tie the requester that did not win last time goes first.
                    gnt_d   = (r0_req_i && r1_req_i) ? ~last_q : r1_req_i;
                    we_d    = gnt_d ? r1_we_i    : r0_we_i;
                    addr_d  = gnt_d ? r1_addr_i  : r0_addr_i;
                    wdata_d = gnt_d ? r1_wdata_i : r0_wdata_i;
                    rdata_d = '0;
                    state_d = StIssue;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            StIssue, StWait: begin
                if (mem_done_i) begin
                    rdata_d = we_q ? '0 : mem_read_data_i;
                    state_d = StResp;
                end else begin
                    state_d = StWait;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TimeoutLimit) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StResp;
                    end
`endif
                end
            end
            StResp: begin
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge core_clk_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign resp             = (state_q == StResp);
    assign busy_o           = (state_q != StIdle);
    assign r0_ack_o         = resp & ~gnt_q;
    assign r1_ack_o         = resp & gnt_q;
    assign r0_rdata_o       = r0_ack_o ? rdata_q : '0;
    assign r1_rdata_o       = r1_ack_o ? rdata_q : '0;
    assign mem_read_en_o    = (state_q == StIssue) & ~we_q;
    assign mem_write_en_o   = (state_q == StIssue) & we_q;
    assign mem_addr_o       = addr_q;
    assign mem_write_data_o = wdata_q;

`ifdef ARB_TIMEOUT_EN
    assign r0_err_o = r0_ack_o & err_q;
    assign r1_err_o = r1_ack_o & err_q;
`else
    assign r0_err_o = 1'b0;
    assign r1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic            core_clk_i = 1'b0;
    logic            core_reset_i = 1'b1;
    logic            r0_req_i = 0, r0_we_i = 0, r1_req_i = 0, r1_we_i = 0;
    logic [XLEN-1:0] r0_addr_i = '0, r0_wdata_i = '0, r1_addr_i = '0, r1_wdata_i = '0;
    logic            r0_ack_o, r0_err_o, r1_ack_o, r1_err_o;
    logic [XLEN-1:0] r0_rdata_o, r1_rdata_o;
    logic [XLEN-1:0] mem_addr_o, mem_write_data_o;
    logic            mem_read_en_o, mem_write_en_o, busy_o;
    logic [XLEN-1:0] mem_read_data_i = '0;
    logic            mem_done_i = 0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .core_clk_i      (core_clk_i),
        .core_reset_i    (core_reset_i),
        .r0_req_i        (r0_req_i),
        .r0_we_i         (r0_we_i),
        .r0_addr_i       (r0_addr_i),
        .r0_wdata_i      (r0_wdata_i),
        .r0_ack_o        (r0_ack_o),
        .r0_rdata_o      (r0_rdata_o),
        .r0_err_o        (r0_err_o),
        .r1_req_i        (r1_req_i),
        .r1_we_i         (r1_we_i),
        .r1_addr_i       (r1_addr_i),
        .r1_wdata_i      (r1_wdata_i),
        .r1_ack_o        (r1_ack_o),
        .r1_rdata_o      (r1_rdata_o),
        .r1_err_o        (r1_err_o),
        .mem_addr_o      (mem_addr_o),
        .mem_write_data_o(mem_write_data_o),
        .mem_read_en_o   (mem_read_en_o),
        .mem_write_en_o  (mem_write_en_o),
        .mem_read_data_i (mem_read_data_i),
        .mem_done_i      (mem_done_i),
        .busy_o          (busy_o)
    );

    always #5 core_clk_i = ~core_clk_i;

    function automatic logic [XLEN-1:0] mem_val(input logic [XLEN-1:0] x);
        return (x * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic tick;
        @(posedge core_clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        core_reset_i = 1'b1;
        r0_req_i = 0; r1_req_i = 0; mem_done_i = 0;
        tick;
        tick;
        core_reset_i = 1'b0;
    endtask

    // One transaction from requester n; reports what was observed, no judgement.
    task automatic run_txn(input int n, input logic we, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] wdata, input int dly,
                           input logic [XLEN-1:0] mdata, output int lat, output int nrd,
                           output int nwr, output logic [XLEN-1:0] rd, output logic er,
                           output logic stable, output logic wrong);
        int  sc;
        bit  fin;
        sc = -1; lat = -1; nrd = 0; nwr = 0; rd = '0; er = 0; stable = 1; wrong = 0; fin = 0;
        if (n == 0) begin
            r0_req_i = 1; r0_we_i = we; r0_addr_i = addr; r0_wdata_i = wdata;
        end else begin
            r1_req_i = 1; r1_we_i = we; r1_addr_i = addr; r1_wdata_i = wdata;
        end
        for (int i = 0; i < 40 && !fin; i++) begin
            tick;
            if (mem_read_en_o) nrd++;
            if (mem_write_en_o) nwr++;
            if ((mem_read_en_o || mem_write_en_o) && sc < 0) sc = cyc;
            if (sc >= 0 && (mem_addr_o !== addr || mem_write_data_o !== wdata)) stable = 0;
            if ((n == 0 && r0_ack_o) || (n == 1 && r1_ack_o)) begin
                lat = cyc - sc;
                rd  = (n == 0) ? r0_rdata_o : r1_rdata_o;
                er  = (n == 0) ? r0_err_o : r1_err_o;
                if (n == 0 && (r1_ack_o || r1_rdata_o != 0 || r1_err_o)) wrong = 1;
                if (n == 1 && (r0_ack_o || r0_rdata_o != 0 || r0_err_o)) wrong = 1;
                r0_req_i = 0; r1_req_i = 0;
                fin = 1;
            end
            mem_done_i      = (sc >= 0 && dly >= 0 && cyc == sc + dly && !fin);
            mem_read_data_i = mem_done_i ? mdata : $urandom;
        end
        mem_done_i = 0; r0_req_i = 0; r1_req_i = 0;
    endtask

    task automatic test_reset;
        logic [4*XLEN+8:0] outs;
        core_reset_i = 1'b1;
        #1;
        outs = {r0_ack_o, r1_ack_o, r0_err_o, r1_err_o, r0_rdata_o, r1_rdata_o, mem_addr_o,
                mem_write_data_o, mem_read_en_o, mem_write_en_o, busy_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0", outs);
        end
        do_reset;
        tick;
        checks++;
        if (busy_o !== 1'b0 || mem_read_en_o !== 1'b0 || mem_write_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b rd=%0b wr=%0b expected 0", busy_o,
                     mem_read_en_o, mem_write_en_o);
        end
    endtask

    task automatic test_single_read;
        int lat, nrd, nwr; logic [XLEN-1:0] rd; logic er, st, wr;
        run_txn(0, 1'b0, 32'h100, 32'h0BAD_F00D, 3, 32'hDEADBEEF, lat, nrd, nwr, rd, er, st, wr);
        checks++;
        if (lat !== 4 || nrd !== 1 || nwr !== 0) begin
            errors++;
            $display("FAIL read_timing: lat=%0d rd=%0d wr=%0d expected 4 1 0", lat, nrd, nwr);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || !st || wr) begin
            errors++;
            $display("FAIL read_data: rdata=%0h err=%0b stable=%0b other=%0b expected deadbeef 0 1 0",
                     rd, er, st, wr);
        end
        tick;
        checks++;
        if (r0_ack_o !== 1'b0 || r0_rdata_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse: ack=%0b rdata=%0h busy=%0b expected 0 0 0", r0_ack_o,
                     r0_rdata_o, busy_o);
        end
    endtask

    task automatic test_write;
        int lat, nrd, nwr; logic [XLEN-1:0] rd; logic er, st, wr;
        run_txn(1, 1'b1, 32'h40, 32'h12345678, 2, 32'hFFFFFFFF, lat, nrd, nwr, rd, er, st, wr);
        checks++;
        if (lat !== 3 || nrd !== 0 || nwr !== 1) begin
            errors++;
            $display("FAIL write_timing: lat=%0d rd=%0d wr=%0d expected 3 0 1", lat, nrd, nwr);
        end
        checks++;
        if (rd !== '0 || er !== 1'b0 || !st || wr) begin
            errors++;
            $display("FAIL write_resp: rdata=%0h err=%0b stable=%0b other=%0b expected 0 0 1 0",
                     rd, er, st, wr);
        end
    endtask

    task automatic test_round_robin;
        int n, sc, last_ack, strobes, who;
        logic [XLEN-1:0] ad[2];
        ad[0] = 32'h200; ad[1] = 32'h300;
        do_reset;
        n = 0; sc = -1; last_ack = -1; strobes = 0;
        r0_req_i = 1; r0_we_i = 0; r0_addr_i = ad[0];
        r1_req_i = 1; r1_we_i = 0; r1_addr_i = ad[1];
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick;
            if (mem_read_en_o || mem_write_en_o) begin
                strobes++;
                sc = cyc;
                if (last_ack >= 0) begin
                    checks++;
                    if (sc !== last_ack + 2) begin
                        errors++;
                        $display("FAIL rr_gap: strobe at %0d expected %0d", sc, last_ack + 2);
                    end
                end
            end
            if (r0_ack_o || r1_ack_o) begin
                who = r1_ack_o ? 1 : 0;
                checks++;
                if (who !== n % 2 || (r0_ack_o && r1_ack_o)) begin
                    errors++;
                    $display("FAIL rr_order: txn %0d granted r%0d expected r%0d", n, who, n % 2);
                end
                checks++;
                if (cyc !== sc + 1) begin
                    errors++;
                    $display("FAIL rr_latency: ack at %0d expected %0d", cyc, sc + 1);
                end
                checks++;
                if ((who ? r1_rdata_o : r0_rdata_o) !== mem_val(ad[n % 2])) begin
                    errors++;
                    $display("FAIL rr_rdata: got %0h expected %0h",
                             who ? r1_rdata_o : r0_rdata_o, mem_val(ad[n % 2]));
                end
                last_ack = cyc;
                n++;
            end
            mem_done_i      = mem_read_en_o;
            mem_read_data_i = mem_val(mem_addr_o);
        end
        mem_done_i = 0; r0_req_i = 0; r1_req_i = 0;
        checks++;
        if (n !== 4 || strobes !== 4) begin
            errors++;
            $display("FAIL rr_count: acks=%0d strobes=%0d expected 4 4", n, strobes);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        do_reset;
        r0_req_i = 1; r0_we_i = 0; r0_addr_i = 32'h80;
        tick; tick; tick;
        core_reset_i = 1'b1;
        #1;
        checks++;
        if ({r0_ack_o, r1_ack_o, mem_read_en_o, mem_write_en_o, busy_o, mem_addr_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%0b addr=%0h expected 0 0", busy_o, mem_addr_o);
        end
        r0_req_i = 0;
        tick;
        core_reset_i = 1'b0;
        mem_done_i = 1; mem_read_data_i = 32'hCAFE0000;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            mem_done_i = 0;
            if (r0_ack_o || r1_ack_o || busy_o || mem_read_en_o || mem_write_en_o
                || r0_rdata_o != 0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_stale: %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_timeout;
        int lat, nrd, nwr; logic [XLEN-1:0] rd; logic er, st, wr;
        do_reset;
`ifdef ARB_TIMEOUT_EN
        run_txn(1, 1'b0, 32'h44, 32'h0, -1, 32'h0, lat, nrd, nwr, rd, er, st, wr);
        checks++;
        if (lat !== TO || er !== 1'b1 || rd !== '0 || nrd !== 1) begin
            errors++;
            $display("FAIL timeout_err: lat=%0d err=%0b rdata=%0h expected %0d 1 0", lat, er, rd, TO);
        end
        tick;
        run_txn(0, 1'b0, 32'h48, 32'h0, TO - 1, 32'h600DD00D, lat, nrd, nwr, rd, er, st, wr);
        checks++;
        if (lat !== TO || er !== 1'b0 || rd !== 32'h600DD00D) begin
            errors++;
            $display("FAIL timeout_done_prio: lat=%0d err=%0b rdata=%0h expected %0d 0 600dd00d",
                     lat, er, rd, TO);
        end
`else
        run_txn(1, 1'b0, 32'h44, 32'h0, 20, 32'h600DD00D, lat, nrd, nwr, rd, er, st, wr);
        checks++;
        if (lat !== 21 || er !== 1'b0 || rd !== 32'h600DD00D) begin
            errors++;
            $display("FAIL long_wait: lat=%0d err=%0b rdata=%0h expected 21 0 600dd00d", lat, er, rd);
        end
`endif
    endtask

    task automatic test_random;
        bit              waiting[2], drop[2], w[2];
        int              raise_c[2], gap[2];
        logic [XLEN-1:0] a[2], wd[2], exp_rd, act_rd, oth_rd;
        int              last_m, owner, sc, dd, done_c, n_done, exp_g;
        bit              infl, done_given, acked, e0, e1;
        do_reset;
        waiting = '{0, 0}; drop = '{0, 0}; gap = '{0, 0}; raise_c = '{0, 0};
        w = '{0, 0}; a = '{0, 0}; wd = '{0, 0};
        last_m = 1; infl = 0; done_given = 0; n_done = 0;
        owner = 0; sc = 0; dd = 0; done_c = 0;
        for (int c = 0; c < 4000 && n_done < 200; c++) begin
            tick;
            if (mem_read_en_o || mem_write_en_o) begin
                e0 = waiting[0] && raise_c[0] <= cyc - 1;
                e1 = waiting[1] && raise_c[1] <= cyc - 1;
                checks++;
                if (infl || (!e0 && !e1)) begin
                    errors++;
                    $display("FAIL rand_strobe: unexpected strobe at %0d inflight=%0b", cyc, infl);
                end else begin
                    exp_g = (e0 && e1) ? ((last_m == 1) ? 0 : 1) : (e1 ? 1 : 0);
                    infl = 1; owner = exp_g; sc = cyc; done_given = 0;
                    dd = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
                    checks++;
                    if (mem_write_en_o !== w[owner] || mem_read_en_o === mem_write_en_o) begin
                        errors++;
                        $display("FAIL rand_kind: rd=%0b wr=%0b expected wr=%0b", mem_read_en_o,
                                 mem_write_en_o, w[owner]);
                    end
                end
            end
            checks++;
            if (busy_o !== infl) begin
                errors++;
                $display("FAIL rand_busy: got %0b expected %0b at %0d", busy_o, infl, cyc);
            end
            if (infl) begin
                checks++;
                if (mem_addr_o !== a[owner] || mem_write_data_o !== wd[owner]) begin
                    errors++;
                    $display("FAIL rand_hold: addr=%0h data=%0h expected %0h %0h", mem_addr_o,
                             mem_write_data_o, a[owner], wd[owner]);
                end
            end
            acked = r0_ack_o | r1_ack_o;
            if (acked) begin
                checks++;
                if (!infl || !done_given || cyc != done_c + 1 || (r0_ack_o && r1_ack_o)
                    || r1_ack_o != (owner == 1)) begin
                    errors++;
                    $display("FAIL rand_ack: ack0=%0b ack1=%0b at %0d expected r%0d at %0d",
                             r0_ack_o, r1_ack_o, cyc, owner, done_c + 1);
                end else begin
                    exp_rd = w[owner] ? '0 : mem_val(a[owner]);
                    act_rd = owner ? r1_rdata_o : r0_rdata_o;
                    oth_rd = owner ? r0_rdata_o : r1_rdata_o;
                    checks++;
                    if (act_rd !== exp_rd || oth_rd !== '0 || r0_err_o || r1_err_o) begin
                        errors++;
                        $display("FAIL rand_rdata: got %0h expected %0h (other %0h)", act_rd,
                                 exp_rd, oth_rd);
                    end
                end
                if (infl) begin
                    last_m = owner; waiting[owner] = 0; drop[owner] = 0;
                    gap[owner] = $urandom_range(0, 3);
                end
                infl = 0;
                n_done++;
            end else begin
                checks++;
                if (r0_rdata_o !== '0 || r1_rdata_o !== '0 || r0_err_o || r1_err_o) begin
                    errors++;
                    $display("FAIL rand_quiet: rdata %0h %0h outside ack", r0_rdata_o, r1_rdata_o);
                end
                if (infl && done_given) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_missing_ack: none at %0d expected at %0d", cyc, done_c + 1);
                    infl = 0; waiting[owner] = 0; drop[owner] = 0; gap[owner] = 2;
                end
            end
            mem_done_i = 0;
            mem_read_data_i = $urandom;
            if (infl && !done_given && cyc == sc + dd) begin
                mem_done_i = 1; done_given = 1; done_c = cyc;
                if (!w[owner]) mem_read_data_i = mem_val(a[owner]);
            end else if (!infl && !acked && $urandom_range(0, 3) == 0) begin
                mem_done_i = 1;
            end
            for (int n = 0; n < 2; n++) begin
                if (!waiting[n]) begin
                    if (gap[n] == 0) begin
                        waiting[n] = 1; raise_c[n] = cyc;
                        w[n] = 1'($urandom); a[n] = $urandom; wd[n] = $urandom;
                    end else begin
                        gap[n]--;
                    end
                end else if (infl && owner == n && !drop[n] && $urandom_range(0, 7) == 0) begin
                    drop[n] = 1;
                end
            end
            r0_req_i = waiting[0] && !drop[0];
            r0_we_i = w[0]; r0_addr_i = a[0]; r0_wdata_i = wd[0];
            r1_req_i = waiting[1] && !drop[1];
            r1_we_i = w[1]; r1_addr_i = a[1]; r1_wdata_i = wd[1];
        end
        mem_done_i = 0; r0_req_i = 0; r1_req_i = 0;
        checks++;
        if (n_done < 200) begin
            errors++;
            $display("FAIL rand_progress: %0d transactions completed expected 200", n_done);
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_write;
        test_round_robin;
        test_reset_mid;
        test_timeout;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: timeout limit, 8-bit, range 1..255.
REQ-003 SHALL have port core_clk_i, input, 1: single clock; all logic rises on this edge.
REQ-004 SHALL have port core_reset_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports rN_req_i, input, 1, for N=0,1: requester N access request, held until rN_ack_o.
REQ-006 SHALL have ports rN_we_i, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports rN_addr_i, input, XLEN, and rN_wdata_i, input, XLEN: request address and write data.
REQ-008 SHALL have ports rN_ack_o, output, 1: one-cycle completion pulse to requester N.
REQ-009 SHALL have ports rN_rdata_o, output, XLEN: read data, valid only with rN_ack_o.
REQ-010 SHALL have ports rN_err_o, output, 1: timeout error, valid only with rN_ack_o.
REQ-011 SHALL have ports mem_addr_o, output, XLEN, and mem_write_data_o, output, XLEN: downstream address and write data.
REQ-012 SHALL have ports mem_read_en_o, output, 1, and mem_write_en_o, output, 1: one-cycle downstream strobes.
REQ-013 SHALL have port mem_read_data_i, input, XLEN: downstream read data, sampled with mem_done_i.
REQ-014 SHALL have port mem_done_i, input, 1: downstream completion pulse.
REQ-015 SHALL have port busy_o, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any rN_req_i is high, SHALL grant one requester, latch its we/addr/wdata, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; last-grant pointer resets to 1, so r0 wins the first tie.
REQ-019 ISSUE: SHALL assert exactly one of mem_read_en_o/mem_write_en_o for one cycle, with the latched addr/wdata driven on mem_addr_o/mem_write_data_o.
REQ-020 In ISSUE or WAIT, mem_done_i high SHALL capture mem_read_data_i (writes capture 0) and move the FSM to RESP; otherwise ISSUE moves to WAIT and WAIT holds.
REQ-021 mem_addr_o and mem_write_data_o SHALL remain stable from ISSUE through RESP.
REQ-022 RESP: SHALL pulse the granted rN_ack_o for one cycle with captured rdata and err, update the last-grant pointer, and return to IDLE.
REQ-023 Minimum latency: request seen in IDLE at cycle T, strobe at T+1, done at T+1 at earliest, ack at T+2; one IDLE cycle always separates transactions.
REQ-024 The non-granted rN_ack_o, rN_rdata_o and rN_err_o SHALL be 0; rdata_o and err_o SHALL be 0 outside the ack cycle.
REQ-025 In IDLE, mem_done_i SHALL be ignored.
REQ-026 A requester dropping rN_req_i after grant SHALL NOT abort the transaction; ack still issues.

Reset
REQ-027 Asserting core_reset_i SHALL immediately force: FSM to IDLE, last-grant pointer to 1, all outputs to 0, and the timeout counter to 0.
REQ-028 Reset mid-transaction SHALL discard the transaction with no ack; a stale mem_done_i after release SHALL be ignored.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE/WAIT without done.
REQ-030 With ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with err_o=1 and rdata_o=0; done in that same cycle SHALL take priority, giving a normal response.
REQ-031 Macro ARB_TIMEOUT_EN undefined: there SHALL be no counter, WAIT SHALL persist until mem_done_i, and rN_err_o SHALL be constant 0.

Verification
REQ-032 r0 read, addr 0x100, done 3 cycles after strobe with data 0xDEADBEEF -> one mem_read_en_o pulse at 0x100; r0_ack_o with rdata 0xDEADBEEF; err 0.
REQ-033 r0 and r1 requests held high together for 4 transactions, done immediate -> grant order r0, r1, r0, r1; each ack exactly 2 cycles after its IDLE grant.
REQ-034 r1 write, addr 0x40, data 0x12345678 -> mem_write_en_o one cycle with both values stable until ack; r1_rdata_o = 0.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, done never arrives -> ack with err_o=1 at count 8; next request is serviced normally.
REQ-036 core_reset_i pulsed in WAIT, then done arrives after release -> no ack; outputs 0; busy_o=0.
REQ-037 mem_done_i in the ISSUE cycle -> RESP the next cycle; no duplicate strobe.
